// File: rtl/axi_lite_master.sv
// axi_lite_master: converts a single-outstanding core memory request
// into one AXI4-lite read (AR/R) or write (AW/W/B) transaction.
// Ports:
//   ACLK, ARESET        clock, async active-high reset
//   mem_req/wen/addr/size/wdata/strb   core request (sampled in IDLE)
//   mem_ack/rdata/error  one-cycle completion pulse with result
//   mem_busy             high while a request is being processed
//   M_AXI_AR*/R*         read address / read data channels
//   M_AXI_AW*/W*/B*      write address / write data / response channels
module axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              mem_req,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_size,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_strb,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_error,
    output logic              mem_busy,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [2:0]        M_AXI_ARSIZE,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic [2:0]        M_AXI_AWSIZE,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [DATA_W-1:0] M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY
);

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_D, WR_AW, WR_B, ERR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        strb_q;
    logic              aw_done;
    logic              w_done;
    logic              aligned;
    logic              aw_hs;
    logic              w_hs;

    // Address and payload are held in the request latch, so the
    // channel signals are stable for as long as VALID is high.
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_ARSIZE = size_q;
    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_AWSIZE = size_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = strb_q;

    assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;

    always_comb begin
        aligned = 1'b0;
        unique case (1'b1)
            mem_size == 3'd0: aligned = 1'b1;
            mem_size == 3'd1: aligned = ~mem_addr[0];
            mem_size == 3'd2: aligned = mem_addr[1:0] == 2'b00;
            default:          aligned = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state         <= IDLE;
            addr_q        <= '0;
            size_q        <= '0;
            wdata_q       <= '0;
            strb_q        <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            mem_ack       <= 1'b0;
            mem_rdata     <= '0;
            mem_error     <= 1'b0;
            mem_busy      <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
        end else begin
            mem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        addr_q    <= mem_addr;
                        size_q    <= mem_size;
                        wdata_q   <= mem_wdata;
                        strb_q    <= mem_strb;
                        mem_error <= 1'b0;
                        mem_busy  <= 1'b1;
                        if (!aligned) begin
                            state <= ERR;
                        end else if (mem_wen) begin
                            state         <= WR_AW;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                        end else begin
                            state         <= RD_A;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_D;
                    end
                end
                RD_D: begin
                    if (M_AXI_RVALID) begin
                        mem_rdata    <= M_AXI_RDATA;
                        mem_error    <= |M_AXI_RRESP;
                        mem_ack      <= 1'b1;
                        mem_busy     <= 1'b0;
                        M_AXI_RREADY <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WR_AW: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    // Either channel may finish first, or both together.
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_B;
                    end
                end
                WR_B: begin
                    if (M_AXI_BVALID) begin
                        mem_error    <= |M_AXI_BRESP;
                        mem_ack      <= 1'b1;
                        mem_busy     <= 1'b0;
                        M_AXI_BREADY <= 1'b0;
                        state        <= IDLE;
                    end
                end
                ERR: begin
                    mem_error <= 1'b1;
                    mem_ack   <= 1'b1;
                    mem_busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Upstream neighbour of the test AXI SRAM.
- Converts the core's single-outstanding memory request interface into AXI4-lite master transactions on the M_AXI_* channels.
- One transaction in flight at a time; FSM sequences the AR/R or AW/W/B handshakes and returns a one-cycle completion pulse with read data and error status to the core.

Parameters:
- ADDR_W, 32, address width of mem_addr and M_AXI_ARADDR/AWADDR
- DATA_W, 32, data width; fixed at 32 by the 4-bit strobe

Ports:
- ACLK  input  1  master clock, rising edge
- ARESET  input  1  asynchronous active-high reset
- mem_req  input  1  core request valid, sampled in IDLE
- mem_wen  input  1  1=write, 0=read
- mem_addr  input  ADDR_W  byte address
- mem_size  input  3  AXI size code: 0=byte, 1=half, 2=word
- mem_wdata  input  DATA_W  write data
- mem_strb  input  4  write byte strobes
- mem_ack  output  1  one-cycle completion pulse
- mem_rdata  output  DATA_W  read data, valid with mem_ack on reads
- mem_error  output  1  error status, valid with mem_ack
- mem_busy  output  1  high whenever state != IDLE
- M_AXI_ARADDR/ARSIZE/ARVALID  output  ADDR_W/3/1  read address channel
- M_AXI_ARREADY  input  1
- M_AXI_RDATA/RRESP/RVALID  input  DATA_W/2/1  read data channel
- M_AXI_RREADY  output  1
- M_AXI_AWADDR/AWSIZE/AWVALID  output  ADDR_W/3/1  write address channel
- M_AXI_AWREADY  input  1
- M_AXI_WDATA/WSTRB/WVALID  output  DATA_W/4/1  write data channel
- M_AXI_WREADY  input  1
- M_AXI_BRESP/BVALID  input  2/1  write response channel
- M_AXI_BREADY  output  1

Behaviour:
- Outputs are registered. While ARESET is high, all outputs are 0 and state is IDLE, including mid-transaction; any in-flight transaction is abandoned.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, ERR.
- IDLE with mem_req=1: latch addr, size, wdata, strb, wen. Then check alignment:
  - size=1 requires addr[0]=0; size=2 requires addr[1:0]=0; size>2 is always illegal.
  - Illegal: go to ERR, no AXI activity.
  - Legal read: go to RD_A with ARVALID=1.
  - Legal write: go to WR_AW with AWVALID=1 and WVALID=1.
- Handshake = VALID&READY at a rising edge. VALID never drops before its handshake; ADDR/SIZE/DATA/STRB stay stable while VALID=1.
- RD_A: on ARREADY, drop ARVALID, set RREADY=1, go to RD_D.
- RD_D: on RVALID, capture RDATA into mem_rdata, set mem_error=(RRESP!=0), pulse mem_ack, drop RREADY, return to IDLE.
- WR_AW: AW and W complete independently. Flags aw_done/w_done each drop their VALID on their own handshake. When both are done (same edge or different edges), set BREADY=1 and go to WR_B.
- WR_B: on BVALID, set mem_error=(BRESP!=0), pulse mem_ack, drop BREADY, return to IDLE.
- ERR: one cycle; pulse mem_ack with mem_error=1, then IDLE.
- mem_ack is high for exactly one cycle, the cycle after the final handshake; state is IDLE during that cycle, so a new mem_req is accepted on that same cycle (back-to-back, no bubble).
- mem_rdata holds its last value until the next read completes. mem_error is cleared when the next request is accepted.
- Minimum latency (READY/VALID always high): read 3 cycles from request to ack; write 3 cycles.

Test Plan:
- Reset then read addr 0x100, size 2, slave always ready, RDATA=0xDEADBEEF -> ARVALID high 1 cycle, ack 3 cycles after req, mem_rdata=0xDEADBEEF, mem_error=0.
- Write 0x0000_0204, wdata 0x12345678, strb 4'b0011, size 2; AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID after 4 cycles, BREADY only after both handshakes, single ack.
- Read with RRESP=2'b10 -> ack with mem_error=1; next good read clears mem_error.
- Misaligned read addr 0x102, size 2, and size=3 request -> ack+error after 2 cycles, ARVALID/AWVALID never asserted.
- Back-to-back: write then read with mem_req held high through ack -> second request accepted on the ack cycle, no idle bubble.
- Assert ARESET while in WR_B -> all outputs 0 immediately (asynchronous), state IDLE, no ack after reset release.
